// File: rtl/md5_byte_hash_core.sv
// Iterative 8-bit reduced-MD5 core: 64 rounds, one per clock, then a finish step
// that folds the saved chaining words into the digest.
module md5_byte_hash_core (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic [7:0]  a0,
   input  logic [7:0]  b0,
   input  logic [7:0]  c0,
   input  logic [7:0]  d0,
   input  logic [31:0] msg,
   input  logic [5:0]  data_in,
   output logic        Done,
   output logic [31:0] digest
);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t      state;
   logic [6:0]  rnd;
   logic [7:0]  a, b, c, d;
   logic [7:0]  sa, sb, sc, sd;
   logic [31:0] m;
   logic [5:0]  tweak;

   logic [5:0]  ri;
   logic [1:0]  i2;
   logic [1:0]  wsel;
   logic [2:0]  sh;
   logic [7:0]  f, k, word, tmp, rot, b_next;

   function automatic logic [7:0] k_rom(input logic [5:0] idx);
      logic [7:0] v;
      case (idx)
         6'd0:  v = 8'h78; 6'd1:  v = 8'h56; 6'd2:  v = 8'hdb; 6'd3:  v = 8'hee;
         6'd4:  v = 8'haf; 6'd5:  v = 8'h2a; 6'd6:  v = 8'h13; 6'd7:  v = 8'h01;
         6'd8:  v = 8'hd8; 6'd9:  v = 8'haf; 6'd10: v = 8'hb1; 6'd11: v = 8'hbe;
         6'd12: v = 8'h22; 6'd13: v = 8'h93; 6'd14: v = 8'h8e; 6'd15: v = 8'h21;
         6'd16: v = 8'h62; 6'd17: v = 8'h40; 6'd18: v = 8'h51; 6'd19: v = 8'haa;
         6'd20: v = 8'h5d; 6'd21: v = 8'h53; 6'd22: v = 8'h81; 6'd23: v = 8'hc8;
         6'd24: v = 8'he6; 6'd25: v = 8'hd6; 6'd26: v = 8'h87; 6'd27: v = 8'hed;
         6'd28: v = 8'h05; 6'd29: v = 8'hf8; 6'd30: v = 8'hd9; 6'd31: v = 8'h8a;
         6'd32: v = 8'h42; 6'd33: v = 8'h81; 6'd34: v = 8'h22; 6'd35: v = 8'h0c;
         6'd36: v = 8'h44; 6'd37: v = 8'ha9; 6'd38: v = 8'h60; 6'd39: v = 8'h70;
         6'd40: v = 8'hc6; 6'd41: v = 8'hfa; 6'd42: v = 8'h85; 6'd43: v = 8'h05;
         6'd44: v = 8'h39; 6'd45: v = 8'he5; 6'd46: v = 8'hf8; 6'd47: v = 8'h65;
         6'd48: v = 8'h44; 6'd49: v = 8'h97; 6'd50: v = 8'ha7; 6'd51: v = 8'h39;
         6'd52: v = 8'hc3; 6'd53: v = 8'h92; 6'd54: v = 8'h7d; 6'd55: v = 8'hd1;
         6'd56: v = 8'h4f; 6'd57: v = 8'he0; 6'd58: v = 8'h14; 6'd59: v = 8'ha1;
         6'd60: v = 8'h82; 6'd61: v = 8'h35; 6'd62: v = 8'hbb; default: v = 8'h91;
      endcase
      return v;
   endfunction

   always_comb begin
      ri   = rnd[5:0];
      i2   = ri[1:0];
      f    = '0;
      wsel = '0;
      sh   = '0;
      // Only g mod 4 is needed, so the index multipliers reduce mod 4 (5->1, 3->3, 7->3)
      case (ri[5:4])
         2'd0: begin f = (b & c) | (~b & d); wsel = i2;                end
         2'd1: begin f = (d & b) | (~d & c); wsel = i2 + 2'd1;         end
         2'd2: begin f = b ^ c ^ d;          wsel = i2 * 2'd3 + 2'd1;  end
         default: begin f = c ^ (b | ~d);    wsel = i2 * 2'd3;         end
      endcase
      case ({ri[5:4], i2})
         4'h0: sh = 3'd7; 4'h1: sh = 3'd4; 4'h2: sh = 3'd1; 4'h3: sh = 3'd6;
         4'h4: sh = 3'd5; 4'h5: sh = 3'd1; 4'h6: sh = 3'd6; 4'h7: sh = 3'd4;
         4'h8: sh = 3'd4; 4'h9: sh = 3'd3; 4'ha: sh = 3'd0; 4'hb: sh = 3'd7;
         4'hc: sh = 3'd6; 4'hd: sh = 3'd2; 4'he: sh = 3'd7; default: sh = 3'd5;
      endcase
      case (wsel)
         2'd0: word = m[7:0];
         2'd1: word = m[15:8];
         2'd2: word = m[23:16];
         default: word = m[31:24];
      endcase
      k   = k_rom(ri) ^ {2'b00, tweak};
      tmp = a + f + k + word;
      case (sh)
         3'd0: rot = tmp;
         3'd1: rot = {tmp[6:0], tmp[7]};
         3'd2: rot = {tmp[5:0], tmp[7:6]};
         3'd3: rot = {tmp[4:0], tmp[7:5]};
         3'd4: rot = {tmp[3:0], tmp[7:4]};
         3'd5: rot = {tmp[2:0], tmp[7:3]};
         3'd6: rot = {tmp[1:0], tmp[7:2]};
         default: rot = {tmp[0], tmp[7:1]};
      endcase
      b_next = b + rot;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state  <= IDLE;
         rnd    <= '0;
         a      <= '0;
         b      <= '0;
         c      <= '0;
         d      <= '0;
         sa     <= '0;
         sb     <= '0;
         sc     <= '0;
         sd     <= '0;
         m      <= '0;
         tweak  <= '0;
         digest <= '0;
         Done   <= 1'b0;
      end else begin
         case (state)
            RUN: begin
               // Count value 64 is the finish step after the last round
               if (rnd == 7'd64) begin
                  digest <= {sa + a, sb + b, sc + c, sd + d};
                  Done   <= 1'b1;
                  state  <= DONE;
               end else begin
                  a   <= d;
                  d   <= c;
                  c   <= b;
                  b   <= b_next;
                  rnd <= rnd + 7'd1;
               end
            end
            default: begin
               if (start) begin
                  a     <= a0;
                  b     <= b0;
                  c     <= c0;
                  d     <= d0;
                  sa    <= a0;
                  sb    <= b0;
                  sc    <= c0;
                  sd    <= d0;
                  m     <= msg;
                  tweak <= data_in;
                  rnd   <= '0;
                  Done  <= 1'b0;
                  state <= RUN;
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_md5_byte_hash_core.sv
// Scoreboard bench for md5_byte_hash_core: stimulus queues expected digests,
// a monitor pops them on each rising Done and also checks the 65-edge latency.
module tb_md5_byte_hash_core;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic [7:0]  a0 = '0, b0 = '0, c0 = '0, d0 = '0;
   logic [31:0] msg = '0;
   logic [5:0]  data_in = '0;
   logic        Done;
   logic [31:0] digest;

   int unsigned n_cmp = 0;
   int unsigned n_bad = 0;
   int unsigned cyc = 0;
   logic        prev_done = 1'b0;

   typedef struct {
      logic [31:0] dig;
      int unsigned start_cyc;
   } exp_t;
   exp_t sb[$];
   exp_t cur;

   localparam logic [7:0] KT [64] = '{
      8'h78, 8'h56, 8'hdb, 8'hee, 8'haf, 8'h2a, 8'h13, 8'h01,
      8'hd8, 8'haf, 8'hb1, 8'hbe, 8'h22, 8'h93, 8'h8e, 8'h21,
      8'h62, 8'h40, 8'h51, 8'haa, 8'h5d, 8'h53, 8'h81, 8'hc8,
      8'he6, 8'hd6, 8'h87, 8'hed, 8'h05, 8'hf8, 8'hd9, 8'h8a,
      8'h42, 8'h81, 8'h22, 8'h0c, 8'h44, 8'ha9, 8'h60, 8'h70,
      8'hc6, 8'hfa, 8'h85, 8'h05, 8'h39, 8'he5, 8'hf8, 8'h65,
      8'h44, 8'h97, 8'ha7, 8'h39, 8'hc3, 8'h92, 8'h7d, 8'hd1,
      8'h4f, 8'he0, 8'h14, 8'ha1, 8'h82, 8'h35, 8'hbb, 8'h91};
   localparam int SHT [16] = '{7, 4, 1, 6, 5, 1, 6, 4, 4, 3, 0, 7, 6, 2, 7, 5};

   md5_byte_hash_core dut (
      .clk(clk), .rst(rst), .start(start),
      .a0(a0), .b0(b0), .c0(c0), .d0(d0),
      .msg(msg), .data_in(data_in),
      .Done(Done), .digest(digest)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [31:0] model(input logic [7:0] ia, ib, ic, id,
                                         input logic [31:0] mm, input logic [5:0] tw);
      logic [7:0] A, B, C, D, F, t, r, nb;
      int g, s;
      A = ia; B = ib; C = ic; D = id;
      for (int i = 0; i < 64; i++) begin
         if (i < 16)      begin F = (B & C) | (~B & D); g = i;                end
         else if (i < 32) begin F = (D & B) | (~D & C); g = (5 * i + 1) % 16; end
         else if (i < 48) begin F = B ^ C ^ D;          g = (3 * i + 5) % 16; end
         else             begin F = C ^ (B | ~D);       g = (7 * i) % 16;     end
         s  = SHT[(i / 16) * 4 + (i % 4)];
         t  = A + F + (KT[i] ^ {2'b00, tw}) + mm[8 * (g % 4) +: 8];
         r  = (t << s) | (t >> (8 - s));
         nb = B + r;
         A = D; D = C; C = B; B = nb;
      end
      return {ia + A, ib + B, ic + C, id + D};
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %08h, expected %08h (t=%0t)", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (Done === 1'b1 && !prev_done) begin
         if (sb.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected_done: got Done=1 with digest %08h, expected no completion", digest);
         end else begin
            cur = sb.pop_front();
            check("digest", digest, cur.dig);
            check("latency", cyc - cur.start_cyc, 32'd65);
         end
      end
      prev_done = (Done === 1'b1);
   end

   task automatic do_reset;
      @(negedge clk);
      rst = 1'b1;
      repeat (2) @(negedge clk);
      check("reset_done", {31'd0, Done}, 32'd0);
      check("reset_digest", digest, 32'd0);
      rst = 1'b0;
   endtask

   task automatic run(input logic [7:0] ia, ib, ic, id, input logic [31:0] mm,
                      input logic [5:0] tw, input bit push);
      exp_t e;
      @(negedge clk);
      a0 = ia; b0 = ib; c0 = ic; d0 = id; msg = mm; data_in = tw;
      start = 1'b1;
      if (push) begin
         e.dig = model(ia, ib, ic, id, mm, tw);
         e.start_cyc = cyc + 1;
         sb.push_back(e);
      end
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic wait_done;
      int n = 0;
      while (Done !== 1'b1 && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (Done !== 1'b1) check("done_timeout", {31'd0, Done}, 32'd1);
   endtask

   logic [31:0] old_dig, d1, d2, first_msg, first_dig, exp_dig;
   logic [31:0] dir_msgs [4] = '{32'h0000_0000, 32'hFFFF_FFFF, 32'h1234_5678, 32'h8000_0001};

   initial begin
      do_reset();
      for (int i = 0; i < 10; i++) begin
         repeat (10) @(negedge clk);
         check("idle_done", {31'd0, Done}, 32'd0);
      end

      exp_dig = model(8'h01, 8'h89, 8'hFE, 8'h76, 32'h0, 6'h0);
      run(8'h01, 8'h89, 8'hFE, 8'h76, 32'h0, 6'h0, 1'b1);
      wait_done();
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         check("hold_digest", digest, exp_dig);
         check("hold_done", {31'd0, Done}, 32'd1);
      end

      for (int i = 1; i < 4; i++) begin
         do_reset();
         run(8'h01, 8'h89, 8'hFE, 8'h76, dir_msgs[i], 6'(i * 7), 1'b1);
         wait_done();
      end

      do_reset();
      run(8'h01, 8'h89, 8'hFE, 8'h76, 32'hCAFE_F00D, 6'h15, 1'b1);
      a0 = 8'h55; b0 = 8'hAA; c0 = 8'h33; d0 = 8'hCC; msg = 32'h0BAD_BEEF; data_in = 6'h2A;
      repeat (30) @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      wait_done();

      old_dig = digest;
      run(8'h10, 8'h20, 8'h30, 8'h40, 32'hDEAD_BEEF, 6'h00, 1'b1);
      check("restart_done_falls", {31'd0, Done}, 32'd0);
      check("restart_old_held", digest, old_dig);
      repeat (40) @(negedge clk);
      check("restart_mid_held", digest, old_dig);
      wait_done();

      do_reset();
      run(8'h01, 8'h89, 8'hFE, 8'h76, 32'h7777_1111, 6'h09, 1'b0);
      repeat (30) @(posedge clk);
      #1 rst = 1'b1;
      #1;
      check("abort_done", {31'd0, Done}, 32'd0);
      check("abort_digest", digest, 32'd0);
      @(negedge clk);
      rst = 1'b0;
      run(8'h01, 8'h89, 8'hFE, 8'h76, 32'h7777_1111, 6'h09, 1'b1);
      wait_done();

      do_reset();
      run(8'h01, 8'h89, 8'hFE, 8'h76, 32'hA5A5_5A5A, 6'h3F, 1'b1);
      wait_done();
      d1 = digest;
      run(8'h01, 8'h89, 8'hFE, 8'h76, 32'hA5A5_5A5A, 6'h00, 1'b1);
      wait_done();
      d2 = digest;
      n_cmp++;
      if (d1 === d2) begin
         n_bad++;
         $display("FAIL tweak_differs: got %08h for both tweaks, expected distinct digests", d1);
      end

      first_msg = '0;
      first_dig = '0;
      for (int i = 0; i < 64; i++) begin
         logic [31:0] mm;
         mm = $urandom;
         do_reset();
         run(8'h01, 8'h89, 8'hFE, 8'h76, mm, 6'h00, 1'b1);
         wait_done();
         if (i == 0) begin
            first_msg = mm;
            first_dig = digest;
         end
      end
      do_reset();
      run(8'h01, 8'h89, 8'hFE, 8'h76, first_msg, 6'h00, 1'b1);
      wait_done();
      check("repeat_identical", digest, first_dig);

      repeat (5) @(negedge clk);
      check("scoreboard_drained", sb.size(), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
